// File: rtl/uart_csr_pkg.sv
`default_nettype none
// ============================================================================
// uart_csr_pkg : register offsets, IE/IP bit indices, STATUS field positions
// Revision     : 1.0
// ============================================================================
package uart_csr_pkg;

    localparam logic [31:0] OFF_TXDATA = 32'h00;
    localparam logic [31:0] OFF_BAUD   = 32'h04;
    localparam logic [31:0] OFF_CTRL   = 32'h08;
    localparam logic [31:0] OFF_RXDATA = 32'h0C;
    localparam logic [31:0] OFF_IE     = 32'h10;
    localparam logic [31:0] OFF_IP     = 32'h14;
    localparam logic [31:0] OFF_STATUS = 32'h18;

    localparam int IP_TX_EMPTY = 0;
    localparam int IP_RX_AVAIL = 1;
    localparam int IP_RX_OVR   = 2;
    localparam int IRQ_W       = 3;

    localparam int ST_TX_CNT   = 0;
    localparam int ST_RX_CNT   = 8;
    localparam int ST_TX_FULL  = 16;
    localparam int ST_TX_EMPTY = 17;
    localparam int ST_RX_FULL  = 18;
    localparam int ST_RX_EMPTY = 19;
    localparam int ST_OVR_CNT  = 24;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TXDATA,
        REG_BAUD,
        REG_CTRL,
        REG_RXDATA,
        REG_IE,
        REG_IP,
        REG_STATUS
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [31:0] off);
        case (off)
            OFF_TXDATA: decode_reg = REG_TXDATA;
            OFF_BAUD:   decode_reg = REG_BAUD;
            OFF_CTRL:   decode_reg = REG_CTRL;
            OFF_RXDATA: decode_reg = REG_RXDATA;
            OFF_IE:     decode_reg = REG_IE;
            OFF_IP:     decode_reg = REG_IP;
            OFF_STATUS: decode_reg = REG_STATUS;
            default:    decode_reg = REG_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock first-word-fall-through FIFO, power-of-two depth
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A push into a full FIFO is dropped even if the same edge pops.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem_q[wr_ptr_q] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_csr_fifo.sv
`default_nettype none
// ============================================================================
// uart_csr_fifo : UART CSR window with TX/RX FIFOs and interrupt logic
// Option        : UART_RX_OVERRUN_EN adds RX overrun flag IP[2] and counter
// Revision      : 1.0
// ============================================================================
module uart_csr_fifo
    import uart_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DATA_W    = 8,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_sel,
    input  logic              WE,
    input  logic              RE,
    input  logic [31:0]       A,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [31:0]       baud_div_out,
    output logic [31:0]       ctrl_out,
    output logic              irq
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [31:0] off_w;
    reg_sel_e    sel_w;
    logic        wr_w, rd_w, ip_wr_w;

    assign off_w   = A - BASE_ADDR;
    assign sel_w   = decode_reg(off_w);
    assign wr_w    = uart_sel & WE;
    assign rd_w    = uart_sel & RE & ~WE;
    assign ip_wr_w = wr_w & (sel_w == REG_IP);

    logic              tx_push_w, tx_pop_w, tx_full_w, tx_empty_w;
    logic [TX_CW-1:0]  tx_count_w;
    logic              rx_pop_w, rx_full_w, rx_empty_w;
    logic [RX_CW-1:0]  rx_count_w;
    logic [DATA_W-1:0] rx_head_w;

    assign tx_push_w = wr_w & (sel_w == REG_TXDATA);
    assign tx_pop_w  = tx_valid & tx_ready;
    assign tx_valid  = ~tx_empty_w;
    assign rx_pop_w  = rd_w & (sel_w == REG_RXDATA);

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_w),
        .pop   (tx_pop_w),
        .wdata (WD[DATA_W-1:0]),
        .rdata (tx_data),
        .full  (tx_full_w),
        .empty (tx_empty_w),
        .count (tx_count_w)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (rx_pop_w),
        .wdata (rx_data),
        .rdata (rx_head_w),
        .full  (rx_full_w),
        .empty (rx_empty_w),
        .count (rx_count_w)
    );

    logic [31:0]      baud_q, baud_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic [IRQ_W-1:0] ie_q, ie_d;
    logic             ip0_q, ip0_d;
    logic             irq_q, irq_d;
    logic             tx_drain_w;
    logic             ip2_w;
    logic [7:0]       ovr_cnt_w;
    logic [IRQ_W-1:0] ie_mask_w;
    logic [IRQ_W-1:0] ip_vec_w;

    // TX count steps 1 -> 0 only when the last word leaves with no push behind it.
    assign tx_drain_w = tx_pop_w & (tx_count_w == TX_CW'(1)) & ~(tx_push_w & ~tx_full_w);

`ifdef UART_RX_OVERRUN_EN
    logic       ovr_ip_q, ovr_ip_d;
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_ip_d  = ovr_ip_q;
        ovr_cnt_d = ovr_cnt_q;
        if (ip_wr_w && WD[IP_RX_OVR]) begin
            ovr_ip_d  = 1'b0;
            ovr_cnt_d = '0;
        end
        if (rx_valid && rx_full_w) begin
            ovr_ip_d = 1'b1;
            if (ovr_cnt_d != 8'hFF) ovr_cnt_d = ovr_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_ip_q  <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            ovr_ip_q  <= ovr_ip_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ip2_w     = ovr_ip_q;
    assign ovr_cnt_w = ovr_cnt_q;
    assign ie_mask_w = 3'b111;
`else
    assign ip2_w     = 1'b0;
    assign ovr_cnt_w = '0;
    assign ie_mask_w = 3'b011;
`endif

    assign ip_vec_w = {ip2_w, ~rx_empty_w, ip0_q};

    always_comb begin
        baud_d = baud_q;
        ctrl_d = ctrl_q;
        ie_d   = ie_q;
        ip0_d  = ip0_q;
        if (wr_w && sel_w == REG_BAUD) baud_d = WD;
        if (wr_w && sel_w == REG_CTRL) ctrl_d = WD;
        if (wr_w && sel_w == REG_IE)   ie_d   = WD[IRQ_W-1:0];
        if (ip_wr_w && WD[IP_TX_EMPTY]) ip0_d = 1'b0;
        if (tx_drain_w) ip0_d = 1'b1;
        irq_d = |(ip_vec_w & ie_q & ie_mask_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q <= '0;
            ctrl_q <= '0;
            ie_q   <= '0;
            ip0_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            baud_q <= baud_d;
            ctrl_q <= ctrl_d;
            ie_q   <= ie_d;
            ip0_q  <= ip0_d;
            irq_q  <= irq_d;
        end
    end

    assign baud_div_out = baud_q;
    assign ctrl_out     = ctrl_q;
    assign irq          = irq_q;

    logic [31:0] status_w;
    logic [31:0] rx_ext_w;

    always_comb begin
        status_w                     = '0;
        status_w[ST_TX_CNT +: 8]     = 8'(tx_count_w);
        status_w[ST_RX_CNT +: 8]     = 8'(rx_count_w);
        status_w[ST_TX_FULL]         = tx_full_w;
        status_w[ST_TX_EMPTY]        = tx_empty_w;
        status_w[ST_RX_FULL]         = rx_full_w;
        status_w[ST_RX_EMPTY]        = rx_empty_w;
        status_w[ST_OVR_CNT +: 8]    = ovr_cnt_w;
    end

    assign rx_ext_w = rx_empty_w ? 32'h0 : 32'(rx_head_w);

    always_comb begin
        RD = '0;
        if (uart_sel && !WE) begin
            case (sel_w)
                REG_BAUD:   RD = baud_q;
                REG_CTRL:   RD = ctrl_q;
                REG_RXDATA: RD = rx_ext_w;
                REG_IE:     RD = {{(32-IRQ_W){1'b0}}, ie_q};
                REG_IP:     RD = {{(32-IRQ_W){1'b0}}, ip_vec_w};
                REG_STATUS: RD = status_w;
                default:    RD = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_csr_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_csr_fifo : directed and randomized checks against a queue-based model
// Revision         : 1.0
// ============================================================================
module tb_uart_csr_fifo;

    localparam logic [31:0] B   = 32'h8000_0000;
    localparam int          TD  = 8;
    localparam int          RDP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_sel = 1'b0, WE = 1'b0, RE = 1'b0;
    logic [31:0] A = '0, WD = '0;
    logic [31:0] RD;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [31:0] baud_div_out, ctrl_out;
    logic        irq;

    always #5 clk = ~clk;

    uart_csr_fifo #(.BASE_ADDR(B), .DATA_W(8), .TX_DEPTH(TD), .RX_DEPTH(RDP)) dut (
        .clk(clk), .rst(rst), .uart_sel(uart_sel), .WE(WE), .RE(RE), .A(A), .WD(WD),
        .RD(RD), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .baud_div_out(baud_div_out),
        .ctrl_out(ctrl_out), .irq(irq)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: FIFOs as bounded queues, registers as plain variables.
    logic [7:0]  m_tx[$];
    logic [7:0]  m_rx[$];
    logic [31:0] m_baud, m_ctrl;
    logic [2:0]  m_ie;
    logic        m_ip0, m_ip2, m_irq;
    int          m_ovr;
`ifdef UART_RX_OVERRUN_EN
    localparam logic [2:0] IE_MASK = 3'b111;
`else
    localparam logic [2:0] IE_MASK = 3'b011;
`endif

    logic [31:0] l_rd;
    logic [7:0]  l_txd;
    logic        l_txv;

    function automatic logic [2:0] ipv();
        return {m_ip2, (m_rx.size() > 0), m_ip0};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s = '0;
        s[7:0]   = 8'(m_tx.size());
        s[15:8]  = 8'(m_rx.size());
        s[16]    = (m_tx.size() == TD);
        s[17]    = (m_tx.size() == 0);
        s[18]    = (m_rx.size() == RDP);
        s[19]    = (m_rx.size() == 0);
        s[31:24] = m_ovr[7:0];
        return s;
    endfunction

    function automatic logic [31:0] exp_rd(input logic sel, input logic we, input logic [31:0] a);
        logic [31:0] off = a - B;
        if (!sel || we) return 32'h0;
        case (off)
            32'h04:  return m_baud;
            32'h08:  return m_ctrl;
            32'h0C:  return (m_rx.size() > 0) ? {24'h0, m_rx[0]} : 32'h0;
            32'h10:  return {29'h0, m_ie};
            32'h14:  return {29'h0, ipv()};
            32'h18:  return exp_status();
            default: return 32'h0;
        endcase
    endfunction

    task automatic cycle(input logic sel, input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] wd, input logic txr, input logic rxv, input logic [7:0] rxd);
        int tx_pre, rx_pre;
        logic wr, rd, drop, irq_nx;
        logic [31:0] off;
        uart_sel = sel; WE = we; RE = re; A = a; WD = wd;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        #1;
        l_rd = RD; l_txd = tx_data; l_txv = tx_valid;
        @(posedge clk);
        tx_pre = m_tx.size(); rx_pre = m_rx.size();
        off = a - B; wr = sel & we; rd = sel & re & ~we;
        irq_nx = |(ipv() & m_ie & IE_MASK);
        if (txr && tx_pre > 0) void'(m_tx.pop_front());
        if (wr && off == 32'h0 && tx_pre < TD) m_tx.push_back(wd[7:0]);
        if (rd && off == 32'h0C && rx_pre > 0) void'(m_rx.pop_front());
        drop = rxv && (rx_pre == RDP);
        if (rxv && rx_pre < RDP) m_rx.push_back(rxd);
        if (wr && off == 32'h04) m_baud = wd;
        if (wr && off == 32'h08) m_ctrl = wd;
        if (wr && off == 32'h10) m_ie = wd[2:0];
        if (wr && off == 32'h14 && wd[0]) m_ip0 = 1'b0;
        if (tx_pre == 1 && m_tx.size() == 0) m_ip0 = 1'b1;
`ifdef UART_RX_OVERRUN_EN
        if (wr && off == 32'h14 && wd[2]) begin m_ip2 = 1'b0; m_ovr = 0; end
        if (drop) begin m_ip2 = 1'b1; if (m_ovr < 255) m_ovr++; end
`else
        if (drop) m_ovr = 0;
`endif
        m_irq = irq_nx;
        @(negedge clk);
        uart_sel = 1'b0; WE = 1'b0; RE = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cycle(1'b1, 1'b1, 1'b0, B + off, d, 1'b0, 1'b0, 8'h0);
    endtask

    task automatic rdr(input logic [31:0] off);
        cycle(1'b1, 1'b0, 1'b1, B + off, 32'h0, 1'b0, 1'b0, 8'h0);
    endtask

    task automatic do_reset(input logic txr, input logic rxv);
        rst = 1'b1; tx_ready = txr; rx_valid = rxv; rx_data = 8'hEE;
        @(posedge clk);
        m_tx.delete(); m_rx.delete();
        m_baud = '0; m_ctrl = '0; m_ie = '0; m_ip0 = 1'b0; m_ip2 = 1'b0; m_ovr = 0; m_irq = 1'b0;
        @(negedge clk);
        rst = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] offs [5] = '{32'h04, 32'h08, 32'h10, 32'h14, 32'h0C};
        do_reset(1'b0, 1'b0);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rdr(32'h18);
        total++; if (l_rd !== 32'h000A_0000) begin bad++; $display("FAIL reset_status got=%h exp=000a0000", l_rd); end
        for (int i = 0; i < 5; i++) begin
            rdr(offs[i]);
            total++; if (l_rd !== 32'h0) begin bad++; $display("FAIL reset_reg off=%h got=%h exp=0", offs[i], l_rd); end
        end
    endtask

    task automatic test_tx_basic();
        logic [31:0] e;
        logic [7:0]  ed;
        wr(32'h10, 32'h1);
        wr(32'h00, 32'h41); wr(32'h00, 32'h42); wr(32'h00, 32'h43);
        e = exp_status();
        rdr(32'h18);
        total++; if (l_rd[7:0] !== 8'd3 || l_rd !== e) begin bad++; $display("FAIL tx_count3 got=%h exp=%h", l_rd, e); end
        total++; if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin bad++; $display("FAIL tx_head got=%h/%b exp=41/1", tx_data, tx_valid); end
        for (int i = 0; i < 3; i++) begin
            ed = m_tx[0];
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h0);
            total++; if (l_txd !== ed || l_txv !== 1'b1) begin bad++; $display("FAIL tx_pop%0d got=%h exp=%h", i, l_txd, ed); end
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
        e = exp_rd(1'b1, 1'b0, B + 32'h14);
        rdr(32'h14);
        total++; if (l_rd[0] !== 1'b1 || l_rd !== e) begin bad++; $display("FAIL tx_ip0 got=%h exp=%h", l_rd, e); end
        total++; if (irq !== 1'b1 || irq !== m_irq) begin bad++; $display("FAIL tx_irq got=%b exp=1", irq); end
        wr(32'h14, 32'h1);
        wr(32'h10, 32'h0);
    endtask

    task automatic test_tx_full();
        logic [31:0] e;
        logic [7:0]  ed;
        for (int i = 0; i < 9; i++) wr(32'h00, $urandom);
        e = exp_status();
        rdr(32'h18);
        total++; if (l_rd[7:0] !== 8'd8 || l_rd[16] !== 1'b1 || l_rd !== e) begin bad++; $display("FAIL tx_full got=%h exp=%h", l_rd, e); end
        for (int i = 0; i < 8; i++) begin
            ed = m_tx[0];
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h0);
            total++; if (l_txd !== ed) begin bad++; $display("FAIL tx_full_drain%0d got=%h exp=%h", i, l_txd, ed); end
        end
        wr(32'h14, 32'h1);
    endtask

    task automatic test_rx_fifo();
        logic [31:0] e;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 9; i++) begin
            e = exp_rd(1'b1, 1'b0, B + 32'h0C);
            rdr(32'h0C);
            total++; if (l_rd !== e) begin bad++; $display("FAIL rx_read%0d got=%h exp=%h", i, l_rd, e); end
        end
        total++; if (l_rd !== 32'h0) begin bad++; $display("FAIL rx_empty_read got=%h exp=0", l_rd); end
        rdr(32'h18);
        total++; if (l_rd[19] !== 1'b1) begin bad++; $display("FAIL rx_empty_flag got=%h exp=bit19", l_rd); end
    endtask

    task automatic test_overrun();
        logic [31:0] e;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'($urandom));
        e = exp_rd(1'b1, 1'b0, B + 32'h14);
        rdr(32'h14);
        total++; if (l_rd !== e) begin bad++; $display("FAIL ovr_ip got=%h exp=%h", l_rd, e); end
`ifdef UART_RX_OVERRUN_EN
        total++; if (l_rd[2] !== 1'b1) begin bad++; $display("FAIL ovr_ip2 got=%b exp=1", l_rd[2]); end
`else
        total++; if (l_rd[2] !== 1'b0) begin bad++; $display("FAIL ovr_ip2 got=%b exp=0", l_rd[2]); end
`endif
        e = exp_status();
        rdr(32'h18);
`ifdef UART_RX_OVERRUN_EN
        total++; if (l_rd[31:24] !== 8'd2 || l_rd !== e) begin bad++; $display("FAIL ovr_cnt got=%h exp=%h", l_rd, e); end
`else
        total++; if (l_rd[31:24] !== 8'd0 || l_rd !== e) begin bad++; $display("FAIL ovr_cnt got=%h exp=%h", l_rd, e); end
`endif
        wr(32'h14, 32'h4);
        rdr(32'h14);
        total++; if (l_rd[2] !== 1'b0) begin bad++; $display("FAIL ovr_clr_ip got=%h exp=bit2 0", l_rd); end
        rdr(32'h18);
        total++; if (l_rd[31:24] !== 8'd0) begin bad++; $display("FAIL ovr_clr_cnt got=%h exp=0", l_rd[31:24]); end
        for (int i = 0; i < 8; i++) rdr(32'h0C);
    endtask

    task automatic test_set_wins();
        wr(32'h00, 32'h5A);
        cycle(1'b1, 1'b1, 1'b0, B + 32'h14, 32'h1, 1'b1, 1'b0, 8'h0);
        rdr(32'h14);
        total++; if (l_rd[0] !== 1'b1 || m_ip0 !== 1'b1) begin bad++; $display("FAIL set_wins got=%h exp=bit0 1", l_rd); end
        wr(32'h14, 32'h1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        cycle(1'b1, 1'b0, 1'b1, B + 32'h0C, 32'h0, 1'b0, 1'b1, 8'h5A);
        total++; if (l_rd !== 32'h0) begin bad++; $display("FAIL b2b_rx_empty_read got=%h exp=0", l_rd); end
        wr(32'h00, 32'h11); wr(32'h00, 32'h22);
        cycle(1'b1, 1'b1, 1'b0, B, 32'h33, 1'b1, 1'b0, 8'h0);
        cycle(1'b1, 1'b0, 1'b1, B + 32'h0C, 32'h0, 1'b0, 1'b1, 8'h6B);
        total++; if (l_rd !== 32'h5A) begin bad++; $display("FAIL b2b_rx_read got=%h exp=5a", l_rd); end
        e = exp_status();
        rdr(32'h18);
        total++; if (l_rd[15:0] !== 16'h0102 || l_rd !== e) begin bad++; $display("FAIL b2b_counts got=%h exp=%h", l_rd, e); end
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b1, B + 32'h0C, 32'h0, 1'b1, 1'b0, 8'h0);
        wr(32'h14, 32'h1);
    endtask

    task automatic test_random();
        logic [31:0] offs [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h02};
        logic sel, we, re, txr, rxv, etxv;
        logic [31:0] a, e;
        logic [7:0] etxd;
        for (int n = 0; n < 400; n++) begin
            sel = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1) == 1;
            re  = $urandom_range(0, 1) == 1;
            a   = ($urandom_range(0, 9) == 0) ? 32'($urandom) : B + offs[$urandom_range(0, 8)];
            txr = ($urandom_range(0, 2) == 0);
            rxv = ($urandom_range(0, 2) == 0);
            e    = exp_rd(sel, we, a);
            etxv = (m_tx.size() > 0);
            etxd = etxv ? m_tx[0] : 8'h0;
            cycle(sel, we, re, a, 32'($urandom), txr, rxv, 8'($urandom));
            total++; if (l_rd !== e) begin bad++; $display("FAIL rnd_rd n=%0d a=%h got=%h exp=%h", n, a, l_rd, e); end
            total++; if (l_txv !== etxv || (etxv && l_txd !== etxd)) begin bad++; $display("FAIL rnd_tx n=%0d got=%b/%h exp=%b/%h", n, l_txv, l_txd, etxv, etxd); end
            total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, m_irq); end
            total++; if (baud_div_out !== m_baud || ctrl_out !== m_ctrl) begin bad++; $display("FAIL rnd_out n=%0d got=%h/%h exp=%h/%h", n, baud_div_out, ctrl_out, m_baud, m_ctrl); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) wr(32'h00, 32'(8'hA0 + i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'(i));
        wr(32'h10, 32'h2);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0);
        total++; if (irq !== 1'b1 || irq !== m_irq) begin bad++; $display("FAIL mid_pre_irq got=%b exp=1", irq); end
        do_reset(1'b1, 1'b1);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_tx_valid got=%b exp=0", tx_valid); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", irq); end
        rdr(32'h18);
        total++; if (l_rd !== 32'h000A_0000) begin bad++; $display("FAIL mid_status got=%h exp=000a0000", l_rd); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_full();
        test_rx_fifo();
        test_overrun();
        test_set_wins();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_csr_fifo.md
UART_CSR_FIFO -- requirements
Module: uart_csr_fifo

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000, is the register window base address.
REQ-002 Parameter DATA_W, default 8, is the character width.
REQ-003 Parameter TX_DEPTH, default 8, is the TX FIFO depth; it SHALL be a power of two and at least 2.
REQ-004 Parameter RX_DEPTH, default 8, is the RX FIFO depth; it SHALL be a power of two and at least 2.
REQ-005 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- uart_sel  in  1  register window select.
- WE  in  1  write strobe.
- RE  in  1  read strobe; qualifies pops.
- A  in  32  byte address.
- WD  in  32  write data.
- RD  out  32  read data, combinational.
- tx_data  out  DATA_W  head of TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  TX engine takes tx_data this cycle.
- rx_data  in  DATA_W  received character.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- baud_div_out  out  32  BAUD register.
- ctrl_out  out  32  CTRL register.
- irq  out  1  interrupt request.

Function
REQ-006 Register offsets from BASE_ADDR SHALL be: 0x00 TXDATA, 0x04 BAUD, 0x08 CTRL, 0x0C RXDATA, 0x10 IE, 0x14 IP, 0x18 STATUS.
REQ-007 A write SHALL take effect on the clk edge where uart_sel & WE & A matches the register.
REQ-008 A TXDATA write SHALL push WD[DATA_W-1:0] only if the TX FIFO is not full; a push while full SHALL be dropped, even if the FIFO pops in the same cycle.
REQ-009 A TX pop SHALL occur on an edge with tx_valid & tx_ready; tx_data SHALL be first-word-fall-through.
REQ-010 An rx_valid strobe SHALL push rx_data into the RX FIFO if the RX FIFO is not full, otherwise the character is dropped.
REQ-011 RD SHALL show the RXDATA head, zero-extended, whenever the read address is RXDATA.
- The pop SHALL occur on the edge with uart_sel & RE & ~WE & A==RXDATA.
- A read while empty returns 0 and does not pop.
REQ-012 When a push and a pop hit the same FIFO in one cycle and the FIFO is neither empty nor full, both SHALL occur and the count SHALL be unchanged.
REQ-013 When the RX FIFO is empty, a same-cycle push and pop read SHALL store the pushed word, and the read SHALL return 0.
REQ-014 BAUD and CTRL SHALL be full 32-bit read/write registers, driven directly on baud_div_out and ctrl_out.
REQ-015 IE[2:0] SHALL be read/write, with upper bits reading 0.
REQ-016 IP[0] (tx_empty) SHALL be sticky: it sets on the edge where the TX count goes 1 to 0 and is cleared by writing 1 to IP[0].
REQ-017 IP[1] (rx_avail) SHALL be a level: 1 while the RX FIFO is non-empty; writes to it are ignored.
REQ-018 If a set event and a write-1-to-clear coincide on IP[0], the set SHALL win.
REQ-019 irq SHALL be registered and equal |(IP & IE) one cycle after any change.
REQ-020 STATUS SHALL be read-only with this layout:
- [7:0] TX count.
- [15:8] RX count.
- [16] tx_full, [17] tx_empty, [18] rx_full, [19] rx_empty.
- Upper bits 0.
REQ-021 RD SHALL be 0 when uart_sel=0, when WE=1, or when the address is unmapped; unmapped writes SHALL have no effect.
REQ-022 FIFO pointers SHALL wrap modulo depth; counts SHALL range from 0 to depth inclusive.

Reset
REQ-023 On rst=1 at a clk edge, the block SHALL reset as follows:
- Both FIFOs empty.
- BAUD, CTRL, IE and IP = 0.
- tx_valid = 0, irq = 0.
- Overrun counter = 0.
REQ-024 A reset asserted mid-operation SHALL discard all FIFO contents; a TX pop or rx_valid in the reset cycle SHALL be ignored.

Configuration
REQ-025 With UART_RX_OVERRUN_EN defined, the overrun function SHALL be compiled in:
- A dropped rx_valid (RX FIFO full) sets sticky IP[2] (W1C, set wins) and increments STATUS[31:24].
- STATUS[31:24] is an 8-bit counter that saturates at 255 and clears on a write to IP with WD[2]=1.
REQ-026 Without UART_RX_OVERRUN_EN, IP[2] and STATUS[31:24] SHALL read 0, and IE[2] SHALL have no effect.

Structure
REQ-027 A shared package uart_csr_pkg SHALL hold the register offset constants, the IE/IP bit indices and the STATUS field positions.
REQ-028 A sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count; synchronous active-high rst) SHALL be instantiated once for TX and once for RX.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Push 0x41,0x42,0x43 with tx_ready=0 -> STATUS[7:0]=3, tx_data=0x41; then tx_ready=1 for 3 cycles -> data 0x41,0x42,0x43 out, IP[0]=1, irq=1 next cycle if IE[0]=1.
- Write 9 characters into the default 8-deep TX FIFO -> 9th dropped, tx_full=1, count 8.
- 8 rx_valid pulses (0x10..0x17) then 8 RXDATA reads -> returns 0x10..0x17 in order, a 9th read returns 0, rx_empty=1.
- Defined build: 10 rx_valid into a full RX FIFO path -> IP[2]=1, STATUS[31:24]=2; W1C IP=0x4 -> both cleared; undefined build: both read 0.
- tx_empty set event coincident with IP write 0x1 -> IP[0] stays 1.
- Assert rst with 5 words queued -> next cycle tx_valid=0, STATUS=0x000A_0000, irq=0.
